// File: rtl/rgb_led_driver.sv
// Drives the physical RGB LED from the game phase color code with PWM dimming,
// and blinks each newly shown non-black color a fixed number of times.
module rgb_led_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DUTY        = 64,
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned BLINK_COUNT = 3,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] RGB_estado,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       blinking,
  output logic [1:0] state_o
);

  // Handshake: none. RGB_estado is a level, sampled every cycle; there is no
  // valid/ready pair because the converter holds its color until the next phase.

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } state_t;

  localparam int HALF_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int PAIR_W = (BLINK_COUNT > 0) ? $clog2(BLINK_COUNT + 1) : 1;
  localparam logic [HALF_W-1:0]   HALF_LAST = HALF_W'(BLINK_HALF - 1);
  localparam logic [PAIR_W-1:0]   PAIR_LAST = PAIR_W'(BLINK_COUNT - 1);
  localparam logic [PWM_BITS-1:0] DUTY_L    = PWM_BITS'(DUTY);
  // With no blink pairs configured a color change settles straight into STEADY.
  localparam state_t START_ST = (BLINK_COUNT == 0) ? STEADY : BLINK_ON;

  state_t              state_q;
  logic [2:0]          col_q;
  logic [2:0]          cur_q;
  logic [HALF_W-1:0]   half_q;
  logic [PAIR_W-1:0]   pair_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [2:0]          led_q;

  logic       lit;
  logic       pwm_on;
  logic [2:0] active;

  generate
    if (DUTY == 0) begin : g_pwm_off
      assign pwm_on = 1'b0;
    end else begin : g_pwm_cmp
      assign pwm_on = (pwm_q < DUTY_L);
    end
  endgenerate

  always_comb begin
    lit    = (state_q != BLINK_OFF);
    active = cur_q & {3{lit & pwm_on}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= STEADY;
      col_q   <= 3'b000;
      cur_q   <= 3'b000;
      half_q  <= '0;
      pair_q  <= '0;
      pwm_q   <= '0;
      led_q   <= {3{ACTIVE_LOW}};
    end else begin
      col_q <= RGB_estado;
      pwm_q <= pwm_q + PWM_BITS'(1);
      led_q <= active ^ {3{ACTIVE_LOW}};
      // A newly sampled color always wins, restarting any blink in progress.
      if (col_q != cur_q) begin
        cur_q   <= col_q;
        half_q  <= '0;
        pair_q  <= '0;
        state_q <= (col_q != 3'b000) ? START_ST : STEADY;
      end else begin
        case (state_q)
          STEADY: begin
            half_q <= '0;
          end
          BLINK_ON: begin
            if (half_q == HALF_LAST) begin
              state_q <= BLINK_OFF;
              half_q  <= '0;
            end else begin
              half_q <= half_q + HALF_W'(1);
            end
          end
          BLINK_OFF: begin
            if (half_q == HALF_LAST) begin
              half_q <= '0;
              if (pair_q == PAIR_LAST) begin
                state_q <= STEADY;
                pair_q  <= '0;
              end else begin
                state_q <= BLINK_ON;
                pair_q  <= pair_q + PAIR_W'(1);
              end
            end else begin
              half_q <= half_q + HALF_W'(1);
            end
          end
          default: state_q <= STEADY;
        endcase
      end
    end
  end

  assign led_r    = led_q[2];
  assign led_g    = led_q[1];
  assign led_b    = led_q[0];
  assign blinking = (state_q == BLINK_ON) || (state_q == BLINK_OFF);
  assign state_o  = state_q;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Bench for rgb_led_driver: three instances (normal, active-low, zero-duty with
// no blink pairs) share one stimulus and are checked against a timeline model.
module tb_rgb_led_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rgb = 3'b000;

  logic       a_r, a_g, a_b, a_bl;
  logic [1:0] a_st;
  logic       b_r, b_g, b_b, b_bl;
  logic [1:0] b_st;
  logic       z_r, z_g, z_b, z_bl;
  logic [1:0] z_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_led_driver #(.PWM_BITS(4), .DUTY(4), .BLINK_HALF(8), .BLINK_COUNT(2), .ACTIVE_LOW(1'b0)) dut_a (
    .clock(clk), .reset(rst), .RGB_estado(rgb),
    .led_r(a_r), .led_g(a_g), .led_b(a_b), .blinking(a_bl), .state_o(a_st));

  rgb_led_driver #(.PWM_BITS(4), .DUTY(4), .BLINK_HALF(8), .BLINK_COUNT(2), .ACTIVE_LOW(1'b1)) dut_b (
    .clock(clk), .reset(rst), .RGB_estado(rgb),
    .led_r(b_r), .led_g(b_g), .led_b(b_b), .blinking(b_bl), .state_o(b_st));

  rgb_led_driver #(.PWM_BITS(4), .DUTY(0), .BLINK_HALF(8), .BLINK_COUNT(0), .ACTIVE_LOW(1'b0)) dut_z (
    .clock(clk), .reset(rst), .RGB_estado(rgb),
    .led_r(z_r), .led_g(z_g), .led_b(z_b), .blinking(z_bl), .state_o(z_st));

  // Timeline model: m_pos counts cycles since the shown color last changed;
  // a blink is 2 pairs of 8 on + 8 off cycles, i.e. 32 cycles.
  localparam int BLINK_LEN = 32;
  logic [2:0] m_col, m_cur, m_led;
  logic [3:0] m_pwm;
  int         m_pos;
  logic       m_blink, m_lit;
  logic [1:0] m_st;

  always_comb begin
    m_blink = (m_pos < BLINK_LEN);
    m_lit   = !m_blink || ((m_pos % 16) < 8);
    m_st    = !m_blink ? 2'd0 : (((m_pos % 16) < 8) ? 2'd1 : 2'd2);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_col <= 3'b000;
      m_cur <= 3'b000;
      m_pos <= BLINK_LEN;
      m_pwm <= 4'd0;
      m_led <= 3'b000;
    end else begin
      m_col <= rgb;
      m_pwm <= m_pwm + 4'd1;
      m_led <= m_cur & {3{m_lit && (m_pwm < 4'd4)}};
      if (m_col != m_cur) begin
        m_cur <= m_col;
        m_pos <= (m_col != 3'b000) ? 0 : BLINK_LEN;
      end else if (m_pos < BLINK_LEN) begin
        m_pos <= m_pos + 1;
      end
    end
  end

  logic [17:0] got_all, exp_all;
  assign got_all = {a_r, a_g, a_b, a_bl, a_st, b_r, b_g, b_b, b_bl, b_st, z_r, z_g, z_b, z_bl, z_st};
  assign exp_all = {m_led, m_blink, m_st, ~m_led, m_blink, m_st, 6'b000000};

  task automatic test_reset();
    rst = 1'b1;
    rgb = 3'b101;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== 18'b000000_111000_000000) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b required %b", k, got_all, 18'b000000_111000_000000);
      end
    end
    rst = 1'b0;
    rgb = 3'b000;
  endtask

  task automatic test_purple();
    int bl_cnt = 0;
    int g_cnt  = 0;
    rgb = 3'b101;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL purple cyc %0d: got %b required %b", k, got_all, exp_all);
      end
      bl_cnt += int'(a_bl);
      g_cnt  += int'(a_g);
    end
    checks++;
    if (bl_cnt !== 32) begin
      errors++;
      $display("FAIL purple_blink_len: got %0d required 32", bl_cnt);
    end
    checks++;
    if (g_cnt !== 0) begin
      errors++;
      $display("FAIL purple_green_dark: got %0d required 0", g_cnt);
    end
  endtask

  task automatic test_steady_gb();
    int g_cnt = 0;
    int b_cnt = 0;
    int r_cnt = 0;
    rgb = 3'b011;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL steady_gb cyc %0d: got %b required %b", k, got_all, exp_all);
      end
      if (k > 54) begin
        g_cnt += int'(a_g);
        b_cnt += int'(a_b);
      end
      if (k > 2) r_cnt += int'(a_r);
    end
    checks++;
    if (g_cnt !== 4 || b_cnt !== 4) begin
      errors++;
      $display("FAIL steady_gb_duty: got g=%0d b=%0d required 4 each", g_cnt, b_cnt);
    end
    checks++;
    if (r_cnt !== 0) begin
      errors++;
      $display("FAIL steady_gb_red: got %0d required 0", r_cnt);
    end
  endtask

  task automatic test_dark();
    rgb = 3'b100;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL dark_pre cyc %0d: got %b required %b", k, got_all, exp_all);
      end
    end
    rgb = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (a_bl !== 1'b0) begin
        errors++;
        $display("FAIL dark_no_blink cyc %0d: got %b required 0", k, a_bl);
      end
      if (k >= 3) begin
        checks++;
        if ({a_r, a_g, a_b} !== 3'b000 || {b_r, b_g, b_b} !== 3'b111) begin
          errors++;
          $display("FAIL dark_pins cyc %0d: got %b/%b required 000/111", k, {a_r, a_g, a_b}, {b_r, b_g, b_b});
        end
      end
    end
  endtask

  task automatic test_restart();
    int bl_cnt = 0;
    int g_cnt  = 0;
    rgb = 3'b011;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL restart cyc %0d: got %b required %b", k, got_all, exp_all);
      end
      bl_cnt += int'(a_bl);
      if (k >= 23) g_cnt += int'(a_g);
      if (k == 20) rgb = 3'b001;
    end
    checks++;
    if (bl_cnt !== 52) begin
      errors++;
      $display("FAIL restart_blink_len: got %0d required 52", bl_cnt);
    end
    checks++;
    if (g_cnt !== 0) begin
      errors++;
      $display("FAIL restart_green_gone: got %0d required 0", g_cnt);
    end
  endtask

  task automatic test_active_low();
    int rb_bad  = 0;
    int g_low   = 0;
    rgb = 3'b010;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL active_low cyc %0d: got %b required %b", k, got_all, exp_all);
      end
      if (k >= 3 && (b_r !== 1'b1 || b_b !== 1'b1)) rb_bad++;
      if (k > 44 && b_g === 1'b0) g_low++;
    end
    checks++;
    if (rb_bad !== 0) begin
      errors++;
      $display("FAIL active_low_idle: got %0d lit cycles on r/b required 0", rb_bad);
    end
    checks++;
    if (g_low !== 4) begin
      errors++;
      $display("FAIL active_low_green: got %0d low cycles required 4", g_low);
    end
  endtask

  task automatic test_reset_mid_blink();
    rgb = 3'b110;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL mid_blink cyc %0d: got %b required %b", k, got_all, exp_all);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (got_all !== 18'b000000_111000_000000) begin
      errors++;
      $display("FAIL reset_mid_blink: got %b required %b", got_all, 18'b000000_111000_000000);
    end
    rst = 1'b0;
    rgb = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got_all !== exp_all) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %b required %b", k, got_all, exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_purple();
    test_steady_gb();
    test_dark();
    test_restart();
    test_active_low();
    test_reset_mid_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
